// File: rtl/gpio_bank_pkg.sv
// Shared constants and register decode for the GPIO bank peripheral.
package gpio_bank_pkg;

    localparam int unsigned GPIO_WB_AD_WIDTH  = 32;
    localparam int unsigned GPIO_WB_DAT_WIDTH = 32;
    localparam int unsigned GPIO_SIZE         = 64;
    localparam int unsigned GPIO_OFFS_W       = $clog2(GPIO_SIZE);

    localparam logic [7:0] GPIO_IN_ADDR     = 8'h00;
    localparam logic [7:0] GPIO_OUT_ADDR    = 8'h04;
    localparam logic [7:0] GPIO_OE_ADDR     = 8'h08;
    localparam logic [7:0] GPIO_SET_ADDR    = 8'h0C;
    localparam logic [7:0] GPIO_CLR_ADDR    = 8'h10;
    localparam logic [7:0] GPIO_IE_ADDR     = 8'h14;
    localparam logic [7:0] GPIO_ITYPE_ADDR  = 8'h18;
    localparam logic [7:0] GPIO_IPOL_ADDR   = 8'h1C;
    localparam logic [7:0] GPIO_IPEND_ADDR  = 8'h20;

    // Word index of each register, i.e. byte offset bits [5:2]
    typedef enum logic [3:0] {
        REG_IN    = 4'(GPIO_IN_ADDR    >> 2),
        REG_OUT   = 4'(GPIO_OUT_ADDR   >> 2),
        REG_OE    = 4'(GPIO_OE_ADDR    >> 2),
        REG_SET   = 4'(GPIO_SET_ADDR   >> 2),
        REG_CLR   = 4'(GPIO_CLR_ADDR   >> 2),
        REG_IE    = 4'(GPIO_IE_ADDR    >> 2),
        REG_ITYPE = 4'(GPIO_ITYPE_ADDR >> 2),
        REG_IPOL  = 4'(GPIO_IPOL_ADDR  >> 2),
        REG_IPEND = 4'(GPIO_IPEND_ADDR >> 2)
    } gpio_reg_e;

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage flop synchroniser for asynchronous inputs; stage 0 samples the pad.
module gpio_sync #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/gpio_bank.sv
// Wishbone GPIO bank: per-pin direction, atomic set/clear, edge/level interrupts
// with sticky W1C pending bits and a single registered interrupt to the PLIC.
module gpio_bank
    import gpio_bank_pkg::*;
#(
    parameter int unsigned NGPIO        = 32,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned WB_AD_WIDTH  = GPIO_WB_AD_WIDTH,
    parameter int unsigned WB_DAT_WIDTH = GPIO_WB_DAT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NGPIO-1:0]          gpio_in_i,
    output logic [NGPIO-1:0]          gpio_out_o,
    output logic [NGPIO-1:0]          gpio_out_enable_o,
    output logic                      gpio_plic_irq_o,
    input  logic                      wbm_gpio_cyc_i,
    input  logic                      wbm_gpio_stb_i,
    input  logic                      wbm_gpio_we_i,
    input  logic [WB_AD_WIDTH-1:0]    wbm_gpio_addr_i,
    input  logic [WB_DAT_WIDTH-1:0]   wbm_gpio_wdata_i,
    input  logic [WB_DAT_WIDTH/8-1:0] wbm_gpio_sel_i,
    output logic [WB_DAT_WIDTH-1:0]   gpio_wbm_rdata_o,
    output logic                      gpio_wbm_ack_o
);

    localparam int unsigned NBYTES = WB_DAT_WIDTH / 8;

    logic [NGPIO-1:0] out_q, out_d, oe_q, oe_d, ie_q, ie_d;
    logic [NGPIO-1:0] itype_q, itype_d, ipol_q, ipol_d, ipend_q, ipend_d, prev_q;
    logic [NGPIO-1:0] sync_c, bmask_c, wval_c, w1c_c, edge_c, level_c;
    logic [WB_DAT_WIDTH-1:0] rdata_q, rdata_d, bmask_full_c;
    logic ack_q, ack_d, irq_q, irq_d;
    logic req_c, wr_c, rd_c;
    gpio_reg_e reg_c;
    logic unused_c;

    gpio_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (NGPIO)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (gpio_in_i),
        .q_o (sync_c)
    );

    // A request is accepted only when no ack is outstanding
    assign req_c = wbm_gpio_cyc_i & wbm_gpio_stb_i & ~ack_q;
    assign wr_c  = req_c & wbm_gpio_we_i;
    assign rd_c  = req_c & ~wbm_gpio_we_i;
    assign ack_d = req_c;
    assign reg_c = gpio_reg_e'(wbm_gpio_addr_i[GPIO_OFFS_W-1:2]);

    for (genvar b = 0; b < NBYTES; b++) begin : g_bmask
        assign bmask_full_c[b*8 +: 8] = {8{wbm_gpio_sel_i[b]}};
    end

    assign bmask_c  = bmask_full_c[NGPIO-1:0];
    assign wval_c   = wbm_gpio_wdata_i[NGPIO-1:0] & bmask_c;
    assign unused_c = ^{wbm_gpio_addr_i, wbm_gpio_wdata_i, bmask_full_c};

    always_comb begin
        out_d   = out_q;
        oe_d    = oe_q;
        ie_d    = ie_q;
        itype_d = itype_q;
        ipol_d  = ipol_q;
        w1c_c   = '0;
        if (wr_c) begin
            case (reg_c)
                REG_OUT:   out_d   = (out_q   & ~bmask_c) | wval_c;
                REG_OE:    oe_d    = (oe_q    & ~bmask_c) | wval_c;
                REG_SET:   out_d   = out_q | wval_c;
                REG_CLR:   out_d   = out_q & ~wval_c;
                REG_IE:    ie_d    = (ie_q    & ~bmask_c) | wval_c;
                REG_ITYPE: itype_d = (itype_q & ~bmask_c) | wval_c;
                REG_IPOL:  ipol_d  = (ipol_q  & ~bmask_c) | wval_c;
                REG_IPEND: w1c_c   = wval_c;
                default:   ;
            endcase
        end
    end

    // Edge pins are sticky with set beating W1C; level pins track the synced pin
    always_comb begin
        edge_c  = itype_q & ((ipol_q & sync_c & ~prev_q) | (~ipol_q & ~sync_c & prev_q));
        level_c = sync_c ^ ~ipol_q;
        ipend_d = (itype_q & ((ipend_q & ~w1c_c) | edge_c)) | (~itype_q & level_c);
        irq_d   = |(ipend_d & ie_d);
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_c) begin
            case (reg_c)
                REG_IN:    rdata_d = WB_DAT_WIDTH'(sync_c);
                REG_OUT:   rdata_d = WB_DAT_WIDTH'(out_q);
                REG_OE:    rdata_d = WB_DAT_WIDTH'(oe_q);
                REG_IE:    rdata_d = WB_DAT_WIDTH'(ie_q);
                REG_ITYPE: rdata_d = WB_DAT_WIDTH'(itype_q);
                REG_IPOL:  rdata_d = WB_DAT_WIDTH'(ipol_q);
                REG_IPEND: rdata_d = WB_DAT_WIDTH'(ipend_q);
                default:   rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            oe_q    <= '0;
            ie_q    <= '0;
            itype_q <= '0;
            ipol_q  <= '0;
            ipend_q <= '0;
            prev_q  <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            oe_q    <= oe_d;
            ie_q    <= ie_d;
            itype_q <= itype_d;
            ipol_q  <= ipol_d;
            ipend_q <= ipend_d;
            prev_q  <= sync_c;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            irq_q   <= irq_d;
        end
    end

    assign gpio_out_o        = out_q;
    assign gpio_out_enable_o = oe_q;
    assign gpio_plic_irq_o   = irq_q;
    assign gpio_wbm_rdata_o  = rdata_q;
    assign gpio_wbm_ack_o    = ack_q;

endmodule
